// File: rtl/line_mem_if.sv
// Line-granular memory port between a cache (master) and its backing store (slave).
// Carries 128-bit lines addressed by a 28-bit line address.
interface line_mem_if;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    modport master (
        output mem_read,
        output mem_write,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/line_mem_responder.sv
// Fixed-latency line memory: serves one 128-bit read or write per request and
// signals completion with a single-cycle mem_ready pulse LATENCY cycles after sampling.
module line_mem_responder #(
    parameter int LATENCY = 4,
    parameter int IDX_W   = 10
) (
    input  logic         clk,
    input  logic         proc_reset,
    line_mem_if.slave    bus
);

    localparam int DEPTH = 1 << IDX_W;
    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 2);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [7:0]         cnt_q;
    logic [7:0]         cnt_d;

    logic               req_we_p0;
    logic [IDX_W-1:0]   req_idx_p0;
    logic [127:0]       req_wdata_p0;

    logic               latch;
    logic               commit;
    logic               commit_we;
    logic [IDX_W-1:0]   commit_idx;
    logic [127:0]       commit_wdata;

    logic [127:0]       rdata_q;
    logic               ready_q;
    logic [127:0]       mem_array [DEPTH];

    logic               req_any;
    logic               unused_addr;

    assign req_any     = bus.mem_read | bus.mem_write;
    assign unused_addr = ^bus.mem_addr[27:IDX_W];

    // Commit source is the live request only when LATENCY=1 lets IDLE jump straight to RESP.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        latch        = 1'b0;
        commit       = 1'b0;
        commit_we    = req_we_p0;
        commit_idx   = req_idx_p0;
        commit_wdata = req_wdata_p0;
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    latch        = 1'b1;
                    commit_we    = bus.mem_write;
                    commit_idx   = bus.mem_addr[IDX_W-1:0];
                    commit_wdata = bus.mem_wdata;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (!req_any) begin
                    state_d = IDLE;
                end else if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    state_d = RESP;
                    commit  = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            req_we_p0    <= 1'b0;
            req_idx_p0   <= '0;
            req_wdata_p0 <= '0;
            rdata_q      <= '0;
            ready_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= commit;
            if (latch) begin
                req_we_p0    <= bus.mem_write;
                req_idx_p0   <= bus.mem_addr[IDX_W-1:0];
                req_wdata_p0 <= bus.mem_wdata;
            end
            if (commit && !commit_we) begin
                rdata_q <= mem_array[commit_idx];
            end
        end
    end

    // Array contents survive reset; only a commit outside reset may modify them.
    always_ff @(posedge clk) begin
        if (commit && commit_we && !proc_reset) begin
            mem_array[commit_idx] <= commit_wdata;
        end
    end

    assign bus.mem_rdata = rdata_q;
    assign bus.mem_ready = ready_q;

endmodule

// File: tb/tb_line_mem_responder.sv
// Scoreboard bench for line_mem_responder: directed scenarios plus random
// read/write traffic against an associative-array memory model.
module tb_line_mem_responder;

    localparam int LAT   = 4;
    localparam int IDX_W = 10;

    logic clk = 1'b0;
    logic proc_reset = 1'b1;
    line_mem_if bus();

    line_mem_responder #(.LATENCY(LAT), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .bus        (bus.slave)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int unsigned  cyc;
        logic [127:0] rdata;
    } exp_t;

    exp_t         exp_q[$];
    logic [127:0] model_mem [int];
    logic [127:0] model_rdata = '0;
    int           pool [8];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!proc_reset && bus.mem_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: mem_ready=1 with no request outstanding (cycle %0d)", cyc);
            end else begin
                e = exp_q.pop_front();
                check("ready_cycle", 128'(cyc), 128'(e.cyc));
                check("rdata", bus.mem_rdata, e.rdata);
            end
        end
    end

    task automatic drop_req();
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    // Issue one request, record the expected response, hold it until ready.
    task automatic issue(input bit we, input bit re, input logic [27:0] addr, input logic [127:0] data);
        exp_t e;
        bit   seen;
        int   idx;
        idx  = int'(addr[IDX_W-1:0]);
        seen = 1'b0;
        @(posedge clk);
        #1;
        bus.mem_write = we;
        bus.mem_read  = re;
        bus.mem_addr  = addr;
        bus.mem_wdata = data;
        if (we) model_mem[idx] = data;
        else    model_rdata    = model_mem[idx];
        e.cyc   = cyc + LAT;
        e.rdata = model_rdata;
        exp_q.push_back(e);
        for (int i = 0; i < LAT + 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.mem_ready) begin
                seen = 1'b1;
            end else if (i >= 1) begin
                bus.mem_addr  = 28'($urandom);
                bus.mem_wdata = {$urandom, $urandom, $urandom, $urandom};
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: no mem_ready for addr %h (cycle %0d)", addr, cyc);
            void'(exp_q.pop_front());
        end
        drop_req();
    endtask

    task automatic expect_quiet(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check(name, 128'(bus.mem_ready), 128'(0));
        end
    endtask

    task automatic abort_write(input logic [27:0] addr, input logic [127:0] data, input int n);
        @(posedge clk);
        #1;
        bus.mem_write = 1'b1;
        bus.mem_addr  = addr;
        bus.mem_wdata = data;
        repeat (n) @(posedge clk);
        #1;
        drop_req();
        expect_quiet("abort_no_ready", LAT + 2);
    endtask

    task automatic reset_in_wait(input logic [27:0] addr, input logic [127:0] data);
        @(posedge clk);
        #1;
        bus.mem_write = 1'b1;
        bus.mem_addr  = addr;
        bus.mem_wdata = data;
        repeat (2) @(posedge clk);
        #2;
        proc_reset = 1'b1;
        #1;
        check("rst_wait_ready", 128'(bus.mem_ready), 128'(0));
        check("rst_wait_rdata", bus.mem_rdata, 128'(0));
        drop_req();
        model_rdata = '0;
        @(posedge clk);
        #2;
        proc_reset = 1'b0;
        expect_quiet("rst_wait_no_ready", LAT + 2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] a;
        logic [127:0] b;
        logic [127:0] c;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;

        repeat (3) @(posedge clk);
        #2;
        proc_reset = 1'b0;

        // Asynchronous reset while idle, then a quiet interval.
        @(posedge clk);
        #3;
        proc_reset = 1'b1;
        #1;
        check("rst_idle_ready", 128'(bus.mem_ready), 128'(0));
        check("rst_idle_rdata", bus.mem_rdata, 128'(0));
        @(posedge clk);
        #2;
        proc_reset = 1'b0;
        expect_quiet("idle_no_ready", 20);

        issue(1'b1, 1'b0, 28'h0000005, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);
        issue(1'b0, 1'b1, 28'h0000005, '0);

        a = {4{32'hAAAA_0003}};
        b = {4{32'hBBBB_0007}};
        issue(1'b1, 1'b0, 28'h0000007, b);
        issue(1'b1, 1'b0, 28'h0000003, a);
        issue(1'b0, 1'b1, 28'h0000007, '0);
        issue(1'b0, 1'b1, 28'h0000003, '0);

        abort_write(28'h0000007, {4{32'h1234_5678}}, 2);
        issue(1'b0, 1'b1, 28'h0000007, '0);

        c = {4{32'hC0DE_0009}};
        issue(1'b1, 1'b1, 28'h0000009, c);
        issue(1'b0, 1'b1, 28'h0000009, '0);

        issue(1'b1, 1'b0, 28'h0000400, {4{32'h0A11_A500}});
        issue(1'b0, 1'b1, 28'h0000000, '0);

        reset_in_wait(28'h0000000, {4{32'hBAD0_BAD0}});
        issue(1'b0, 1'b1, 28'h0000800, '0);

        for (int i = 0; i < 8; i++) begin
            pool[i] = int'($urandom_range(0, (1 << IDX_W) - 1));
            issue(1'b1, 1'b0, {18'($urandom), 10'(pool[i])},
                  {$urandom, $urandom, $urandom, $urandom});
        end
        for (int i = 0; i < 40; i++) begin
            int unsigned op;
            int          k;
            op = $urandom_range(0, 9);
            k  = int'($urandom_range(0, 7));
            if (op < 5)
                issue(1'b0, 1'b1, {18'($urandom), 10'(pool[k])}, '0);
            else
                issue(1'b1, op == 9, {18'($urandom), 10'(pool[k])},
                      {$urandom, $urandom, $urandom, $urandom});
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (LAT + 5) @(posedge clk);
        check("pending_responses", 128'(exp_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
